// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared definitions for the PWM soft-start/retarget sequencer.
package pwm_ramp_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PEND     = 3'd1,
    ST_RAMP     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_STOPPING = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pwm_ramp_sequencer_period_div.sv
// Periods-per-step down-counter; load wins over decrement, expire flags the
// boundary on which the decrement reaches zero.
module pwm_ramp_sequencer_period_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 expire
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - DIV_WIDTH'(1);
    end
  end

  assign expire = (count <= DIV_WIDTH'(1));

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/retarget controller stepping a pwm high_time toward a target,
// with every output update landing on the pwm last_cycle boundary.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DIV_WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_WAVE  = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_wave_length,
  input  logic [WIDTH-1:0]     cfg_target,
  input  logic [WIDTH-1:0]     cfg_step,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 stop,
  input  logic                 last_cycle,
  output logic [WIDTH-1:0]     wave_length,
  output logic [WIDTH-1:0]     high_time,
  output logic                 busy,
  output logic                 done
);

  seq_state_t           state;
  logic [WIDTH-1:0]     sh_wave;
  logic [WIDTH-1:0]     sh_target;
  logic [WIDTH-1:0]     sh_step;
  logic [DIV_WIDTH-1:0] sh_div;
  logic [DIV_WIDTH-1:0] div_reload;
  logic                 accept;
  logic                 div_load;
  logic                 div_dec;
  logic                 div_expire;
  logic [WIDTH-1:0]     pend_base;
  logic [WIDTH-1:0]     pend_next;
  logic [WIDTH-1:0]     ramp_next;

  // One extra bit of headroom so neither direction wraps; never passes tgt.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] stp);
    logic [WIDTH:0] cur_x;
    logic [WIDTH:0] tgt_x;
    logic [WIDTH:0] stp_x;
    logic [WIDTH:0] nxt_x;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    stp_x = {1'b0, stp};
    if (stp == '0) begin
      nxt_x = tgt_x;
    end else if (cur_x < tgt_x) begin
      nxt_x = cur_x + stp_x;
      if (nxt_x >= tgt_x) nxt_x = tgt_x;
    end else if (stp_x >= (cur_x - tgt_x)) begin
      nxt_x = tgt_x;
    end else begin
      nxt_x = cur_x - stp_x;
    end
    return nxt_x[WIDTH-1:0];
  endfunction

  assign cfg_ready  = ((state == ST_IDLE) || (state == ST_HOLD)) && !stop;
  assign accept     = cfg_valid && cfg_ready;
  assign busy       = (state == ST_PEND) || (state == ST_RAMP);
  assign div_reload = (sh_div == '0) ? DIV_WIDTH'(1) : sh_div;
  assign div_load   = last_cycle && !stop &&
                      ((state == ST_PEND) || ((state == ST_RAMP) && div_expire));
  assign div_dec    = last_cycle && !stop && (state == ST_RAMP);

  // A shorter new period pulls high_time straight to the (already clamped) target.
  assign pend_base = (high_time > sh_wave) ? sh_target : high_time;
  assign pend_next = step_toward(pend_base, sh_target, sh_step);
  assign ramp_next = step_toward(high_time, sh_target, sh_step);

  pwm_ramp_sequencer_period_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (div_load),
    .load_val(div_reload),
    .dec     (div_dec),
    .expire  (div_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wave_length <= RST_WAVE;
      high_time   <= '0;
      done        <= 1'b0;
      sh_wave     <= '0;
      sh_target   <= '0;
      sh_step     <= '0;
      sh_div      <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        if ((state == ST_STOPPING) && last_cycle) begin
          high_time <= '0;
          state     <= ST_IDLE;
        end else begin
          state <= ST_STOPPING;
        end
      end else begin
        unique case (state)
          ST_IDLE, ST_HOLD: begin
            if (accept) begin
              sh_wave   <= cfg_wave_length;
              sh_target <= (cfg_target < cfg_wave_length) ? cfg_target : cfg_wave_length;
              sh_step   <= cfg_step;
              sh_div    <= cfg_div;
              state     <= ST_PEND;
            end
          end
          ST_PEND: begin
            if (last_cycle) begin
              wave_length <= sh_wave;
              high_time   <= pend_next;
              if (pend_next == sh_target) begin
                done  <= 1'b1;
                state <= ST_HOLD;
              end else begin
                state <= ST_RAMP;
              end
            end
          end
          ST_RAMP: begin
            if (last_cycle && div_expire) begin
              high_time <= ramp_next;
              if (ramp_next == sh_target) begin
                done  <= 1'b1;
                state <= ST_HOLD;
              end
            end
          end
          ST_STOPPING: begin
            if (last_cycle) begin
              high_time <= '0;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed scenarios plus random configs checked
// against an expected per-boundary high_time trajectory.
module tb_pwm_ramp_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_wave_length;
  logic [15:0] cfg_target;
  logic [15:0] cfg_step;
  logic [7:0]  cfg_div;
  logic        stop;
  logic        last_cycle;
  logic [15:0] wave_length;
  logic [15:0] high_time;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int m_high;
  int m_wave;

  pwm_ramp_sequencer #(
    .WIDTH    (16),
    .DIV_WIDTH(8),
    .RST_WAVE (16'hFFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_wave_length(cfg_wave_length),
    .cfg_target     (cfg_target),
    .cfg_step       (cfg_step),
    .cfg_div        (cfg_div),
    .stop           (stop),
    .last_cycle     (last_cycle),
    .wave_length    (wave_length),
    .high_time      (high_time),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boundary();
    last_cycle = 1'b1;
    tick();
    last_cycle = 1'b0;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input int w, input int t, input int s, input int d);
    cfg_wave_length = w[15:0];
    cfg_target      = t[15:0];
    cfg_step        = s[15:0];
    cfg_div         = d[7:0];
    cfg_valid       = 1'b1;
  endtask

  // Expected trajectory: list of high_time values, one per step, computed from
  // the target clamp and the saturating step rule; steps fall div boundaries apart.
  task automatic run_cfg(input int w, input int t, input int s, input int d);
    int tgt;
    int v;
    int dv;
    int exp_q[$];
    tgt = (t < w) ? t : w;
    v   = (m_high > w) ? tgt : m_high;
    do begin
      if (s == 0 || ((tgt > v) ? (tgt - v) : (v - tgt)) <= s) v = tgt;
      else if (tgt > v) v = v + s;
      else v = v - s;
      exp_q.push_back(v);
    end while (v != tgt);
    dv = (d == 0) ? 1 : d;

    offer(w, t, s, d);
    #1;
    chk("cfg_ready_offer", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("hold_before_boundary", high_time, m_high);
    chk("wave_before_boundary", wave_length, m_wave);
    chk("ready_while_busy", cfg_ready, 0);

    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        for (int j = 0; j < dv - 1; j++) begin
          idle_gap();
          boundary();
          chk("ramp_wait_high", high_time, exp_q[k-1]);
          chk("ramp_wait_done", done, 0);
        end
      end
      idle_gap();
      boundary();
      chk("ramp_step_high", high_time, exp_q[k]);
      chk("ramp_step_wave", wave_length, w);
      chk("ramp_step_done", done, (k == exp_q.size() - 1) ? 1 : 0);
    end
    chk("busy_in_hold", busy, 0);
    idle_gap();
    boundary();
    chk("hold_high", high_time, tgt);
    chk("hold_done", done, 0);
    m_high = tgt;
    m_wave = w;
  endtask

  initial begin
    rst             = 1'b1;
    cfg_valid       = 1'b0;
    cfg_wave_length = '0;
    cfg_target      = '0;
    cfg_step        = '0;
    cfg_div         = '0;
    stop            = 1'b0;
    last_cycle      = 1'b0;

    // Reset and idle boundaries
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wave", wave_length, 16'hFFFF);
    chk("rst_high", high_time, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      boundary();
      chk("idle_wave", wave_length, 16'hFFFF);
      chk("idle_high", high_time, 0);
    end
    m_high = 0;
    m_wave = 16'hFFFF;

    // Ramp up, retarget down, jump back, then clamp
    run_cfg(99, 40, 10, 2);
    run_cfg(99, 5, 20, 1);
    run_cfg(99, 40, 0, 0);
    run_cfg(30, 50, 5, 1);
    chk("clamp_wave", wave_length, 30);
    chk("clamp_high", high_time, 30);

    // Stop mid-ramp while a config is offered
    run_cfg(99, 0, 0, 1);
    offer(99, 60, 10, 1);
    tick();
    cfg_valid = 1'b0;
    boundary();
    chk("stop_pre_10", high_time, 10);
    boundary();
    chk("stop_pre_20", high_time, 20);
    stop = 1'b1;
    offer(99, 7, 0, 1);
    #1;
    chk("stop_ready_low", cfg_ready, 0);
    tick();
    stop      = 1'b0;
    cfg_valid = 1'b0;
    chk("stopping_busy", busy, 0);
    chk("stopping_ready", cfg_ready, 0);
    tick();
    chk("stopping_high", high_time, 20);
    boundary();
    chk("stop_high", high_time, 0);
    chk("stop_wave", wave_length, 99);
    chk("stop_done", done, 0);
    chk("stop_ready", cfg_ready, 1);
    boundary();
    chk("stop_idle_high", high_time, 0);
    chk("stop_idle_done", done, 0);
    m_high = 0;
    m_wave = 99;

    // Reset mid-ramp
    offer(50, 50, 1, 1);
    tick();
    cfg_valid = 1'b0;
    boundary();
    boundary();
    chk("pre_rst_high", high_time, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_wave", wave_length, 16'hFFFF);
    chk("mid_rst_high", high_time, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    rst = 1'b0;
    m_high = 0;
    m_wave = 16'hFFFF;

    // Random configs, consecutive boundaries included
    for (int n = 0; n < 8; n++) begin
      int w, t, s, d;
      w = $urandom_range(0, 300);
      t = $urandom_range(0, 320);
      s = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
      d = $urandom_range(0, 3);
      run_cfg(w, t, s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
